// File: rtl/cmp_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit comparator.
// Each granted request takes one compare cycle, then holds its result until it is consumed.
module cmp_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [2:0]  i_req0_funct3,
  input  logic [3:0]  i_req0_tag,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [2:0]  i_req1_funct3,
  input  logic [3:0]  i_req1_tag,
  output logic [31:0] o_cmp_a,
  output logic [31:0] o_cmp_b,
  output logic        o_cmp_un,
  input  logic        i_cmp_less,
  input  logic        i_cmp_equal,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_result,
  output logic        o_rsp_id,
  output logic [3:0]  o_rsp_tag,
  input  logic        i_flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  funct3_q;
  logic        un_q;
  logic [3:0]  tag_q;
  logic        id_q;
  logic        result_q;
  logic        last_id_q;

  logic        accept_d;
  logic        grant_id_d;
  logic        can_accept_d;
  logic [31:0] sel_a_d;
  logic [31:0] sel_b_d;
  logic [2:0]  sel_funct3_d;
  logic [3:0]  sel_tag_d;

  function automatic logic is_unsigned(input logic [2:0] f3);
    case (f3)
      3'b011, 3'b110, 3'b111: is_unsigned = 1'b1;
      default:                is_unsigned = 1'b0;
    endcase
  endfunction

  function automatic logic eval_result(input logic [2:0] f3, input logic less, input logic equal);
    case (f3)
      3'b000:                         eval_result = equal;
      3'b001:                         eval_result = ~equal;
      3'b010, 3'b100, 3'b011, 3'b110: eval_result = less;
      3'b101, 3'b111:                 eval_result = ~less;
      default:                        eval_result = 1'b0;
    endcase
  endfunction

  // Grant selection: a new request may enter from IDLE or when the held result is consumed.
  always_comb begin
    can_accept_d = 1'b0;
    grant_id_d   = 1'b0;
    if (i_flush) begin
      can_accept_d = 1'b0;
    end else if (state_q == IDLE) begin
      can_accept_d = 1'b1;
    end else if (state_q == RESP) begin
      can_accept_d = i_rsp_ready;
    end else begin
      can_accept_d = 1'b0;
    end
    if (i_req0_valid && i_req1_valid) begin
      grant_id_d = ~last_id_q;
    end else if (i_req1_valid) begin
      grant_id_d = 1'b1;
    end else begin
      grant_id_d = 1'b0;
    end
    accept_d     = can_accept_d & (i_req0_valid | i_req1_valid);
    sel_a_d      = grant_id_d ? i_req1_a      : i_req0_a;
    sel_b_d      = grant_id_d ? i_req1_b      : i_req0_b;
    sel_funct3_d = grant_id_d ? i_req1_funct3 : i_req0_funct3;
    sel_tag_d    = grant_id_d ? i_req1_tag    : i_req0_tag;
  end

  assign o_req0_ready = accept_d & ~grant_id_d;
  assign o_req1_ready = accept_d &  grant_id_d;

  // FSM plus operand/result registers; last_id_q resets to 1 so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      funct3_q  <= 3'd0;
      un_q      <= 1'b0;
      tag_q     <= 4'd0;
      id_q      <= 1'b0;
      result_q  <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      if (accept_d) begin
        a_q       <= sel_a_d;
        b_q       <= sel_b_d;
        funct3_q  <= sel_funct3_d;
        un_q      <= is_unsigned(sel_funct3_d);
        tag_q     <= sel_tag_d;
        id_q      <= grant_id_d;
        last_id_q <= grant_id_d;
      end
      if (i_flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= accept_d ? CMP : IDLE;
          CMP: begin
            result_q <= eval_result(funct3_q, i_cmp_less, i_cmp_equal);
            state_q  <= RESP;
          end
          RESP: begin
            if (i_rsp_ready) begin
              state_q <= accept_d ? CMP : IDLE;
            end else begin
              state_q <= RESP;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_cmp_a      = a_q;
  assign o_cmp_b      = b_q;
  assign o_cmp_un     = un_q;
  assign o_rsp_valid  = (state_q == RESP);
  assign o_rsp_result = result_q;
  assign o_rsp_id     = id_q;
  assign o_rsp_tag    = tag_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: a scoreboard learns each accepted request and checks its response.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [3:0]  req0_tag, req1_tag;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_un, cmp_less, cmp_equal;
  logic        rsp_valid, rsp_ready, rsp_result, rsp_id;
  logic [3:0]  rsp_tag;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       id;
    logic [3:0] tag;
    logic       result;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // External comparator model feeding the arbiter.
  assign cmp_less  = cmp_un ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));
  assign cmp_equal = (cmp_a == cmp_b);

  cmp_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_funct3(req0_funct3), .i_req0_tag(req0_tag),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_funct3(req1_funct3), .i_req1_tag(req1_tag),
    .o_cmp_a(cmp_a), .o_cmp_b(cmp_b), .o_cmp_un(cmp_un),
    .i_cmp_less(cmp_less), .i_cmp_equal(cmp_equal),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_result),
    .o_rsp_id(rsp_id), .o_rsp_tag(rsp_tag), .i_flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_result(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    logic lt_s, lt_u, eq;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    eq   = (a == b);
    case (f3)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b010, 3'b100: return lt_s;
      3'b011, 3'b110: return lt_u;
      3'b101:         return !lt_s;
      default:        return !lt_u;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on response handshake, push on request handshake; flush/reset discard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(e.result));
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        end
      end
      if (req0_ready) sb.push_back('{1'b0, req0_tag, exp_result(req0_a, req0_b, req0_funct3)});
      if (req1_ready) sb.push_back('{1'b1, req1_tag, exp_result(req1_a, req1_b, req1_funct3)});
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_funct3 = 3'd0; req0_tag = 4'd0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_funct3 = 3'd0; req1_tag = 4'd0;
    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_readies", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_rsp_fields", 32'({rsp_result, rsp_id, rsp_tag}), 32'd0);
    check("rst_cmp", cmp_a | cmp_b | 32'(cmp_un), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single request 5 < 7 signed, tag 3.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_funct3 = 3'b100; req0_tag = 4'd3;
    #1;
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    check("t1_cmp_valid_low", 32'(rsp_valid), 32'd0);
    check("t1_cmp_a", cmp_a, 32'd5);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp", 32'({rsp_result, rsp_id, rsp_tag}), 32'({1'b1, 1'b0, 4'd3}));
    tick();
    check("t1_idle", 32'(rsp_valid), 32'd0);

    // Signed vs unsigned on 0xFFFFFFFF vs 1.
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_funct3 = 3'b100; req0_tag = 4'd4;
    tick();
    req0_valid = 1'b0;
    check("t2_un_signed", 32'(cmp_un), 32'd0);
    tick();
    check("t2_res_signed", 32'(rsp_result), 32'd1);
    tick();
    req0_valid = 1'b1; req0_funct3 = 3'b110; req0_tag = 4'd5;
    tick();
    req0_valid = 1'b0;
    check("t2_un_unsigned", 32'(cmp_un), 32'd1);
    tick();
    check("t2_res_unsigned", 32'(rsp_result), 32'd0);
    tick();

    // Reset again so the contested sequence starts from the reset pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_funct3 = 3'b000; req0_tag = 4'd6;
    req1_valid = 1'b1; req1_a = 32'd3;  req1_b = 32'd3;  req1_funct3 = 3'b101; req1_tag = 4'd9;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_ready0", 32'(req0_ready), 32'((i % 2) == 0));
      check("rr_ready1", 32'(req1_ready), 32'((i % 2) == 1));
      if (i > 0) check("rr_rsp_id", 32'({rsp_valid, rsp_id}), 32'({1'b1, 1'((i - 1) % 2)}));
      tick();
      check("rr_cmp_gap", 32'({rsp_valid, req0_ready, req1_ready}), 32'd0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("rr_last_rsp", 32'({rsp_valid, rsp_id}), 32'({1'b1, 1'b1}));
    tick();

    // Backpressure: result held five cycles, waiting requester not accepted.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd50; req0_funct3 = 3'b101; req0_tag = 4'hA;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_b = 32'd2; req1_funct3 = 3'b000; req1_tag = 4'hB;
    for (int i = 0; i < 5; i++) begin
      req1_a = 32'(i + 7);
      #1;
      check("bp_hold", 32'({rsp_valid, rsp_result, rsp_tag}), 32'({1'b1, 1'b1, 4'hA}));
      check("bp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
    end
    req1_a = 32'd2; rsp_ready = 1'b1;
    #1;
    check("bp_accept", 32'({rsp_valid, req1_ready}), 32'd3);
    tick();
    req1_valid = 1'b0;
    tick();
    check("bp_next_rsp", 32'({rsp_valid, rsp_result, rsp_tag}), 32'({1'b1, 1'b1, 4'hB}));
    tick();

    // Flush in CMP, then flush blocking an IDLE accept.
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_funct3 = 3'b000; req0_tag = 4'd7;
    tick();
    req0_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_no_rsp", 32'(rsp_valid), 32'd0);
    flush = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_funct3 = 3'b010; req1_tag = 4'd8;
    #1;
    check("fl_idle_block", 32'(req1_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_after_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("fl_cmp_gap", 32'(rsp_valid), 32'd0);
    tick();
    check("fl_next_rsp", 32'({rsp_valid, rsp_id, rsp_tag}), 32'({1'b1, 1'b1, 4'd8}));
    tick();

    // Asynchronous reset while a response is held.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_funct3 = 3'b000; req0_tag = 4'd2;
    tick();
    req0_valid = 1'b0;
    tick();
    check("ar_in_resp", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_drop", 32'(rsp_valid), 32'd0);
    check("ar_rsp_fields", 32'({rsp_result, rsp_id, rsp_tag}), 32'd0);
    check("ar_cmp", cmp_a | cmp_b | 32'(cmp_un), 32'd0);
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    tick();
    tick();
    check("ar_no_rsp", 32'(rsp_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
